// File: rtl/cpu_axil_bridge.sv
// CPU request port to AXI4-Lite master bridge.
// Exactly one transaction in flight; every AXI-facing output is a flop.
module cpu_axil_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WRITE, WRESP, READ, RRESP
  } state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   be_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      arvalid_q;
  logic                      bready_q;
  logic                      rready_q;
  logic                      rsp_valid_q;
  logic                      rsp_err_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic                      aw_done_d;
  logic                      w_done_d;
  logic                      unused_bits;

  // A channel counts as done once its valid has dropped or it handshakes now.
  assign aw_done_d = !awvalid_q || m_axi_awready;
  assign w_done_d  = !wvalid_q || m_axi_wready;

  assign unused_bits = ^{req_addr[1:0], m_axi_bresp[0], m_axi_rresp[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (req_write) begin
              state_q   <= WRITE;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= READ;
              arvalid_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            state_q  <= WRESP;
            bready_q <= 1'b1;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            state_q     <= IDLE;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= m_axi_bresp[1];
            rsp_rdata_q <= '0;
          end
        end
        READ: begin
          if (m_axi_arready) begin
            state_q   <= RRESP;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RRESP: begin
          if (m_axi_rvalid) begin
            state_q     <= IDLE;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= m_axi_rresp[1];
            rsp_rdata_q <= m_axi_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = be_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: doc/cpu_axil_bridge.md
CPU_AXIL_BRIDGE -- requirements
Module: cpu_axil_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI/CPU byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed; other values are unsupported.
REQ-003 SHALL have one clock and a synchronous, active-high reset, named as in the port list below.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 req_valid in 1 / req_write in 1 / req_addr in ADDR_WIDTH / req_wdata in 32 / req_be in 4: CPU request; req_be is byte enables.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 rsp_valid out 1 / rsp_rdata out 32 / rsp_err out 1: completion pulse, read data, and error flag.
REQ-009 m_axi_awaddr out ADDR_WIDTH / m_axi_awprot out 3 / m_axi_awvalid out 1 / m_axi_awready in 1: AXI4-Lite write address channel.
REQ-010 m_axi_wdata out 32 / m_axi_wstrb out 4 / m_axi_wvalid out 1 / m_axi_wready in 1: AXI4-Lite write data channel.
REQ-011 m_axi_bresp in 2 / m_axi_bvalid in 1 / m_axi_bready out 1: AXI4-Lite write response channel.
REQ-012 m_axi_araddr out ADDR_WIDTH / m_axi_arprot out 3 / m_axi_arvalid out 1 / m_axi_arready in 1: AXI4-Lite read address channel.
REQ-013 m_axi_rdata in 32 / m_axi_rresp in 2 / m_axi_rvalid in 1 / m_axi_rready out 1: AXI4-Lite read data channel.

Function
REQ-014 SHALL implement the FSM states IDLE, WRITE, WRESP, READ and RRESP, with exactly one transaction outstanding.
REQ-015 req_ready SHALL be 1 iff the state is IDLE.
REQ-016 On acceptance in IDLE, SHALL latch {addr[ADDR_WIDTH-1:2],2'b00}, wdata and be, then go to WRITE if req_write, else to READ.
REQ-017 In WRITE, SHALL assert awvalid and wvalid from the cycle after acceptance.
REQ-018 In WRITE, each valid SHALL drop independently the cycle after its own handshake; the state SHALL go to WRESP once both handshakes complete.
REQ-019 Both handshakes in the same cycle SHALL be legal, and a W handshake before AW SHALL be legal.
REQ-020 wstrb SHALL equal the latched be; be==0 SHALL still issue the write.
REQ-021 In WRESP, bready SHALL be 1; on bvalid the state SHALL go to IDLE.
REQ-022 In READ, arvalid SHALL be held until arready, then the state SHALL go to RRESP.
REQ-023 In RRESP, rready SHALL be 1; on rvalid the block SHALL capture rdata and go to IDLE.
REQ-024 rsp_valid SHALL pulse for exactly 1 cycle, the cycle after the B or R handshake.
REQ-025 rsp_err SHALL equal resp[1] (SLVERR/DECERR) with rsp_valid.
REQ-026 rsp_rdata SHALL equal the captured rdata on a read and 0 on a write, held until the next rsp_valid.
REQ-027 Back-to-back: a new request SHALL be acceptable in the same cycle rsp_valid is high (state already IDLE).
REQ-028 All AXI valids, readies and payloads SHALL be registered.
REQ-029 There SHALL be no combinational path from any AXI input to any AXI output.
REQ-030 AXI payload SHALL be stable while the corresponding valid is high.
REQ-031 awprot and arprot SHALL be constant 3'b000.
REQ-032 Minimum latency with a zero-wait slave SHALL be: write accept at N -> AW/W handshake N+1 -> B N+2 -> rsp_valid N+3; read accept at N -> AR N+1 -> R N+2 -> rsp_valid N+3.
REQ-033 Backpressure: any number of wait cycles on any ready or valid SHALL be tolerated, with no timeout.
REQ-034 Changes to req_* while not in IDLE SHALL be ignored.

Reset
REQ-035 With rst high at a clock edge, the state SHALL go to IDLE and all valids, bready, rready, rsp_valid and rsp_err SHALL go to 0.
REQ-036 With rst high at a clock edge, rsp_rdata and the latched payload SHALL go to 0.
REQ-037 Reset mid-transaction SHALL abandon the transaction with no rsp_valid; the AXI slave is reset by the same system reset.
REQ-038 After reset, req_ready SHALL be 1 in the first cycle rst is low.

Verification
REQ-039 Zero-wait slave: write 0x00000001 to 0x0, then read 0x0 -> rsp_valid at N+3 each, rsp_rdata=0x00000001, rsp_err=0.
REQ-040 Sequential: write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back each -> rsp_rdata 1,2,3,4 in order, all rsp_err=0.
REQ-041 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one B, one rsp_valid.
REQ-042 Slave returns bresp=2'b10 on write, rresp=2'b11 on read -> rsp_err=1 both; read rsp_rdata equals slave rdata.
REQ-043 req_addr=0x00000007 read -> araddr=0x00000004.
REQ-044 rst asserted the cycle after AW handshake -> awvalid, wvalid, bready 0 next cycle, no rsp_valid, req_ready=1 after rst low.
